// File: rtl/grom_io_pkg.sv
// -----------------------------------------------------------------------------
// grom_io_pkg
// Shared definitions for the grom8 I/O display controller:
//   - byte offsets of the port bank (relative to PORT_BASE)
//   - scan FSM state encoding
//   - hex nibble -> 7-segment lookup table, segments ordered {G,F,E,D,C,B,A},
//     active high
// -----------------------------------------------------------------------------
package grom_io_pkg;

   localparam logic [7:0] DIGIT_BASE = 8'h00;  // first digit-pair port
   localparam int         PAIR_CNT   = 4;      // digit-pair ports 0x00..0x03
   localparam logic [7:0] CTRL_OFS   = 8'h10;  // bit 0: display enable
   localparam logic [7:0] LED_OFS    = 8'h11;  // bits [3:0]: LED register

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_GAP  = 2'd1,
      ST_SHOW = 2'd2
   } scan_state_t;

   // Index 0 is the rightmost entry.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/grom_io_display_if.sv
// -----------------------------------------------------------------------------
// grom_io_display_if
// CPU I/O bus as seen by the display controller.
//   addr   CPU address (ADDR_W bits)
//   data   CPU write data
//   we     write strobe
//   ioreq  I/O cycle qualifier
//   rdata  registered read data returned by the controller
// master: CPU side; slave: controller side.
// -----------------------------------------------------------------------------
interface grom_io_display_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              we;
   logic              ioreq;
   logic [7:0]        rdata;

   modport master (
      output addr, data, we, ioreq,
      input  rdata
   );

   modport slave (
      input  addr, data, we, ioreq,
      output rdata
   );
endinterface

// File: rtl/grom_io_seg_decode.sv
// -----------------------------------------------------------------------------
// grom_io_seg_decode
// Purely combinational hex nibble -> 7-segment decoder.
//   nibble    in   4  hex value 0..F
//   segments  out  7  {G,F,E,D,C,B,A}, active high
// -----------------------------------------------------------------------------
module grom_io_seg_decode
   import grom_io_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segments
);

   assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/grom_io_display.sv
// -----------------------------------------------------------------------------
// grom_io_display
// Memory-mapped I/O display controller for grom8. Decodes CPU I/O cycles to a
// small byte-port bank holding DIGITS hex nibbles, a control register and an
// LED register, and time-multiplexes one 7-segment bus across DIGITS digit
// selects with a one-cycle blanking gap between digits.
//
// Ports:
//   i_Clk        in   1       system clock, rising edge
//   i_Reset_n    in   1       synchronous, active-low reset
//   bus          slave        CPU I/O bus (addr, data, we, ioreq, rdata)
//   o_Segments   out  7       {G,F,E,D,C,B,A}, active high
//   o_Digit_Sel  out  DIGITS  one-hot digit enable, bit 0 = least significant
//   o_LED        out  4       LED register
//
// Build option: define GROM_IO_LZB_EN to enable leading-zero blanking.
// -----------------------------------------------------------------------------
module grom_io_display
   import grom_io_pkg::*;
#(
   parameter int                DIGITS    = 2,
   parameter int                SCAN_DIV  = 1024,
   parameter int                ADDR_W    = 12,
   parameter logic [ADDR_W-1:0] PORT_BASE = '0
) (
   input  logic              i_Clk,
   input  logic              i_Reset_n,
   grom_io_display_if.slave  bus,
   output logic [6:0]        o_Segments,
   output logic [DIGITS-1:0] o_Digit_Sel,
   output logic [3:0]        o_LED
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] pair_ofs;
   logic [1:0]        pair_sel;
   logic              hit_pair;
   logic              hit_ctrl;
   logic              hit_led;
   logic              wr_stb;
   logic              rd_stb;

   always_comb begin
      offset   = bus.addr - PORT_BASE;
      pair_ofs = offset - ADDR_W'(DIGIT_BASE);
      hit_pair = (pair_ofs < ADDR_W'(PAIR_CNT));
      hit_ctrl = (offset == ADDR_W'(CTRL_OFS));
      hit_led  = (offset == ADDR_W'(LED_OFS));
      pair_sel = pair_ofs[1:0];
      wr_stb   = bus.ioreq & bus.we;
      rd_stb   = bus.ioreq & ~bus.we;
   end

   // ---------------------------------------------------------------------
   // Register bank
   // ---------------------------------------------------------------------
   logic [3:0] digit_q [DIGITS];
   logic       en_q;
   logic [3:0] led_q;

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            digit_q[i] <= 4'h0;
         end
         en_q  <= 1'b1;
         led_q <= 4'h0;
      end else if (wr_stb) begin
         if (hit_pair) begin
            // Only digits that exist are stored; the rest of a pair is dropped.
            for (int i = 0; i < DIGITS; i++) begin
               if (2'(i / 2) == pair_sel) begin
                  digit_q[i] <= i[0] ? bus.data[7:4] : bus.data[3:0];
               end
            end
         end
         if (hit_ctrl) begin
            en_q <= bus.data[0];
         end
         if (hit_led) begin
            led_q <= bus.data[3:0];
         end
      end
   end

   assign o_LED = led_q;

   // Read mux: absent digits and unmapped offsets read as zero.
   logic [7:0] rd_val;

   always_comb begin
      rd_val = 8'h00;
      if (hit_pair) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (2'(i / 2) == pair_sel) begin
               if (i[0]) begin
                  rd_val[7:4] = digit_q[i];
               end else begin
                  rd_val[3:0] = digit_q[i];
               end
            end
         end
      end else if (hit_ctrl) begin
         rd_val = {7'b0, en_q};
      end else if (hit_led) begin
         rd_val = {4'b0, led_q};
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         bus.rdata <= 8'h00;
      end else if (rd_stb) begin
         bus.rdata <= rd_val;
      end
   end

   // ---------------------------------------------------------------------
   // Scan FSM
   // ---------------------------------------------------------------------
   scan_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         state_q <= ST_GAP;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!en_q) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_GAP;
               cnt_d   = '0;
               idx_d   = '0;
            end
            ST_GAP: begin
               state_d = ST_SHOW;
            end
            ST_SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                  state_d = ST_GAP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Select the current digit and build its one-hot enable.
   logic [3:0]        cur_nib;
   logic [DIGITS-1:0] sel_oh;

   always_comb begin
      cur_nib = 4'h0;
      sel_oh  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IDX_W'(i) == idx_q) begin
            cur_nib   = digit_q[i];
            sel_oh[i] = 1'b1;
         end
      end
   end

   logic blank;

`ifdef GROM_IO_LZB_EN
   // Walk from the most significant digit down; a digit is a leading zero
   // when it and everything above it are zero. Digit 0 always shows.
   logic lead_zero;

   always_comb begin
      lead_zero = 1'b1;
      blank     = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lead_zero = lead_zero & (digit_q[i] == 4'h0);
         if ((i != 0) && (IDX_W'(i) == idx_q)) begin
            blank = lead_zero;
         end
      end
   end
`else
   assign blank = 1'b0;
`endif

   logic [6:0] seg_dec;

   grom_io_seg_decode u_seg_decode (
      .nibble   (cur_nib),
      .segments (seg_dec)
   );

   // ---------------------------------------------------------------------
   // Output register: follows the FSM state by one cycle, but is gated by
   // the live enable so clearing enable darkens the display on the next edge.
   // ---------------------------------------------------------------------
   logic [6:0]        seg_p1;
   logic [DIGITS-1:0] sel_p1;

   always_ff @(posedge i_Clk) begin
      if (!i_Reset_n) begin
         seg_p1 <= 7'h00;
         sel_p1 <= '0;
      end else if (en_q && (state_q == ST_SHOW)) begin
         seg_p1 <= blank ? 7'h00 : seg_dec;
         sel_p1 <= sel_oh;
      end else begin
         seg_p1 <= 7'h00;
         sel_p1 <= '0;
      end
   end

   assign o_Segments  = seg_p1;
   assign o_Digit_Sel = sel_p1;

endmodule

// File: tb/tb_grom_io_display.sv
// -----------------------------------------------------------------------------
// tb_grom_io_display
// Self-checking bench for grom_io_display (DIGITS=3, SCAN_DIV=8, nonzero
// PORT_BASE). A behavioural model keeps the registers and a single scan-phase
// count per cycle; all outputs are compared after every clock edge, with
// additional directed checks at the interesting points.
// -----------------------------------------------------------------------------
module tb_grom_io_display;

   localparam int          D      = 3;
   localparam int          S      = 8;
   localparam int          AW     = 12;
   localparam logic [11:0] BASE   = 12'h100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [6:0]   seg;
   logic [D-1:0] sel;
   logic [3:0]   led;

   grom_io_display_if #(.ADDR_W(AW)) bus ();

   grom_io_display #(
      .DIGITS    (D),
      .SCAN_DIV  (S),
      .ADDR_W    (AW),
      .PORT_BASE (BASE)
   ) dut (
      .i_Clk       (clk),
      .i_Reset_n   (rst_n),
      .bus         (bus),
      .o_Segments  (seg),
      .o_Digit_Sel (sel),
      .o_LED       (led)
   );

   always #5 clk = ~clk;

   int n_pass   = 0;
   int n_checks = 0;

   // Reference model state
   logic [3:0]   m_dig [D];
   logic         m_en;
   logic [3:0]   m_led;
   logic [7:0]   m_rdata;
   int           m_ph;      // scan phase since (re)start; -1 while off
   logic [6:0]   e_seg;
   logic [D-1:0] e_sel;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      n_checks++;
      assert (obs === want) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, want);
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   function automatic logic lzb_blank(input int slot);
      if (slot == 0) return 1'b0;
      for (int j = slot; j < D; j++) begin
         if (m_dig[j] != 4'h0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic int ofs_of(input logic [11:0] a);
      logic [11:0] o;
      o = a - BASE;
      return int'(o);
   endfunction

   function automatic logic [7:0] ref_read(input logic [11:0] a);
      int off;
      logic [7:0] r;
      off = ofs_of(a);
      r   = 8'h00;
      if (off < 4) begin
         if (2 * off < D)     r[3:0] = m_dig[2 * off];
         if (2 * off + 1 < D) r[7:4] = m_dig[2 * off + 1];
      end else if (off == 'h10) begin
         r = {7'b0, m_en};
      end else if (off == 'h11) begin
         r = {4'b0, m_led};
      end
      return r;
   endfunction

   task automatic ref_write(input logic [11:0] a, input logic [7:0] d);
      int off;
      off = ofs_of(a);
      if (off < 4) begin
         if (2 * off < D)     m_dig[2 * off]     = d[3:0];
         if (2 * off + 1 < D) m_dig[2 * off + 1] = d[7:4];
      end else if (off == 'h10) begin
         m_en = d[0];
      end else if (off == 'h11) begin
         m_led = d[3:0];
      end
   endtask

   // Advance the model by one clock edge using the values held before the edge.
   task automatic model_edge();
      logic en_pre;
      int   slot;
      if (!rst_n) begin
         for (int i = 0; i < D; i++) m_dig[i] = 4'h0;
         m_en    = 1'b1;
         m_led   = 4'h0;
         m_rdata = 8'h00;
         m_ph    = 0;
         e_seg   = 7'h00;
         e_sel   = '0;
         return;
      end
      e_seg = 7'h00;
      e_sel = '0;
      if (m_en && (m_ph >= 0) && ((m_ph % (S + 1)) != 0)) begin
         slot        = (m_ph / (S + 1)) % D;
         e_sel[slot] = 1'b1;
         e_seg       = ref_seg(m_dig[slot]);
`ifdef GROM_IO_LZB_EN
         if (lzb_blank(slot)) e_seg = 7'h00;
`endif
      end
      if (bus.ioreq && !bus.we) m_rdata = ref_read(bus.addr);
      en_pre = m_en;
      if (bus.ioreq && bus.we) ref_write(bus.addr, bus.data);
      if (!en_pre)       m_ph = -1;
      else if (m_ph < 0) m_ph = 0;
      else               m_ph++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("seg",   {1'b0, seg},        {1'b0, e_seg});
      chk("sel",   {{(8-D){1'b0}}, sel}, {{(8-D){1'b0}}, e_sel});
      chk("led",   {4'b0, led},        {4'b0, m_led});
      chk("rdata", bus.rdata,          m_rdata);
   endtask

   task automatic idle(input int n);
      bus.ioreq = 1'b0;
      bus.we    = 1'b0;
      repeat (n) tick();
   endtask

   task automatic io_write(input logic [7:0] off, input logic [7:0] d);
      bus.addr  = BASE + 12'(off);
      bus.data  = d;
      bus.we    = 1'b1;
      bus.ioreq = 1'b1;
      tick();
      bus.ioreq = 1'b0;
      bus.we    = 1'b0;
   endtask

   task automatic io_read(input logic [7:0] off);
      bus.addr  = BASE + 12'(off);
      bus.we    = 1'b0;
      bus.ioreq = 1'b1;
      tick();
      bus.ioreq = 1'b0;
   endtask

   initial begin
      int r;
      logic [7:0] off;
      rst_n     = 1'b0;
      bus.addr  = '0;
      bus.data  = '0;
      bus.we    = 1'b0;
      bus.ioreq = 1'b0;
      m_ph      = 0;

      // Reset
      idle(3);
      chk("rst_seg", {1'b0, seg}, 8'h00);
      chk("rst_sel", {5'b0, sel}, 8'h00);
      chk("rst_rdata", bus.rdata, 8'h00);
      rst_n = 1'b1;

      // Gap, then digit 0 showing "0"
      idle(1);
      chk("gap0_sel", {5'b0, sel}, 8'h00);
      idle(1);
      chk("d0_sel", {5'b0, sel}, 8'h01);
      chk("d0_seg", {1'b0, seg}, 8'h3F);
      idle(S - 1);
      idle(1);
      chk("gap1_sel", {5'b0, sel}, 8'h00);
      idle(1);
      chk("d1_sel", {5'b0, sel}, 8'h02);
      idle(2 * D * (S + 1));

      // Digit pair 0 = A5, read back
      io_write(8'h00, 8'hA5);
      idle(D * (S + 1));
      io_read(8'h00);
      chk("rd_a5", bus.rdata, 8'hA5);

      // Pair 1: only digit 2 exists
      io_write(8'h01, 8'hFF);
      io_read(8'h01);
      chk("rd_0f", bus.rdata, 8'h0F);
      idle(2 * D * (S + 1));

      // Disable mid-scan, re-enable restarts at digit 0
      idle(4);
      io_write(8'h10, 8'h00);
      idle(1);
      chk("off_seg", {1'b0, seg}, 8'h00);
      chk("off_sel", {5'b0, sel}, 8'h00);
      idle(5);
      io_write(8'h10, 8'h01);
      idle(2);
      chk("reen_gap", {5'b0, sel}, 8'h00);
      idle(1);
      chk("reen_d0", {5'b0, sel}, 8'h01);
      chk("reen_seg", {1'b0, seg}, 8'h6D);

      // LED, control read, unmapped offset
      io_write(8'h11, 8'hF3);
      chk("led_3", {4'b0, led}, 8'h03);
      io_read(8'h11);
      chk("rd_led", bus.rdata, 8'h03);
      io_write(8'h20, 8'hFF);
      io_read(8'h20);
      chk("rd_unmap", bus.rdata, 8'h00);
      io_read(8'h10);
      chk("rd_ctrl", bus.rdata, 8'h01);

      // Digits 2,1,0 = 0,7,0
      io_write(8'h00, 8'h70);
      io_write(8'h01, 8'h00);
      io_write(8'h10, 8'h00);
      io_write(8'h10, 8'h01);
      idle(3);
      chk("z_d0_sel", {5'b0, sel}, 8'h01);
      chk("z_d0_seg", {1'b0, seg}, 8'h3F);
      idle(S + 1);
      chk("z_d1_sel", {5'b0, sel}, 8'h02);
      chk("z_d1_seg", {1'b0, seg}, 8'h07);
      idle(S + 1);
      chk("z_d2_sel", {5'b0, sel}, 8'h04);
`ifdef GROM_IO_LZB_EN
      chk("z_d2_seg", {1'b0, seg}, 8'h00);
`else
      chk("z_d2_seg", {1'b0, seg}, 8'h3F);
`endif
      idle(D * (S + 1));

      // Randomized bus traffic, with one reset pulse in the middle
      for (int k = 0; k < 600; k++) begin
         if (k == 300) begin
            rst_n = 1'b0;
            idle(1);
            rst_n = 1'b1;
         end
         r = $urandom_range(0, 11);
         case (r)
            0, 1, 2, 3: off = 8'(r);
            4:          off = 8'h10;
            5:          off = 8'h11;
            6:          off = 8'h20;
            7:          off = 8'($urandom_range(0, 255));
            default:    off = 8'h00;
         endcase
         bus.addr  = BASE + 12'(off);
         bus.data  = 8'($urandom);
         if (off == 8'h10) bus.data[0] = ($urandom_range(0, 3) != 0);
         bus.we    = ($urandom_range(0, 1) == 1);
         bus.ioreq = (r < 8) && ($urandom_range(0, 3) != 0);
         tick();
      end
      idle(2 * D * (S + 1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
